// File: rtl/car_sequencer.sv
// car_sequencer: microcode sequencer owning the control address register and IR.
// Optional single-step HALT support is compiled in when CARSEQ_SINGLE_STEP_EN is defined.
module car_sequencer #(
    parameter int          CAR_BITS  = 6,
    parameter int unsigned CAR_FETCH = 0,
    parameter int unsigned CAR_INT   = 62
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [15:0]         iw,
    input  logic                iw_valid,
    output logic                iw_ready,
    output logic [15:0]         ir,
    input  logic [CAR_BITS-1:0] dec_car,
    input  logic [1:0]          uop,
    input  logic [CAR_BITS-1:0] utarget,
    input  logic                ucond,
    input  logic                stall,
    input  logic                irq,
    input  logic                gie,
`ifdef CARSEQ_SINGLE_STEP_EN
    input  logic                step_en,
    input  logic                step,
`endif
    output logic [CAR_BITS-1:0] car,
    output logic                in_irq,
    output logic                irq_ack,
    output logic                seq_err
);

    // state    | meaning
    // FETCH    | CAR parked at fetch routine, waiting for an instruction word
    // DISPATCH | one cycle for the decoder to settle on the new IR
    // EXEC     | stepping the instruction microroutine
    // IRQ      | stepping the interrupt-entry microroutine
    // HALT     | single-step pause between instructions (optional)
    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DISPATCH,
        ST_EXEC,
        ST_IRQ
`ifdef CARSEQ_SINGLE_STEP_EN
        , ST_HALT
`endif
    } state_t;

    localparam logic [1:0] UOP_NEXT     = 2'd0;
    localparam logic [1:0] UOP_JUMP     = 2'd1;
    localparam logic [1:0] UOP_DISPATCH = 2'd2;
    localparam logic [1:0] UOP_END      = 2'd3;

    localparam logic [CAR_BITS-1:0] C_FETCH = CAR_BITS'(CAR_FETCH);
    localparam logic [CAR_BITS-1:0] C_INT   = CAR_BITS'(CAR_INT);

    state_t              r_state;
    logic [CAR_BITS-1:0] r_car;
    logic [15:0]         r_ir;
    logic                r_in_irq;
    logic                r_irq_ack;
    logic                r_seq_err;

    logic [CAR_BITS-1:0] w_car_inc;
    logic                w_car_max;
    logic                w_in_irq_state;
    logic                w_take_irq;

    assign w_car_inc      = r_car + CAR_BITS'(1);
    assign w_car_max      = &r_car;
    assign w_in_irq_state = (r_state == ST_IRQ);
    assign w_take_irq     = !w_in_irq_state && irq && gie;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_FETCH;
            r_car     <= C_FETCH;
            r_ir      <= 16'h0000;
            r_in_irq  <= 1'b0;
            r_irq_ack <= 1'b0;
            r_seq_err <= 1'b0;
        end else if (stall) begin
            r_irq_ack <= 1'b0;
        end else begin
            r_irq_ack <= 1'b0;
            case (r_state)
                ST_FETCH: begin
                    if (iw_valid) begin
                        r_ir    <= iw;
                        r_state <= ST_DISPATCH;
                    end
                end
                ST_DISPATCH: begin
                    r_car   <= dec_car;
                    r_state <= ST_EXEC;
                end
                ST_EXEC, ST_IRQ: begin
                    if (uop == UOP_END) begin
                        if (w_take_irq) begin
                            r_car     <= C_INT;
                            r_in_irq  <= 1'b1;
                            r_irq_ack <= 1'b1;
                            r_state   <= ST_IRQ;
`ifdef CARSEQ_SINGLE_STEP_EN
                        end else if (!w_in_irq_state && step_en) begin
                            r_car   <= C_FETCH;
                            r_state <= ST_HALT;
`endif
                        end else begin
                            r_car    <= C_FETCH;
                            r_in_irq <= 1'b0;
                            r_state  <= ST_FETCH;
                        end
                    end else if (uop == UOP_DISPATCH && !w_in_irq_state) begin
                        r_car <= dec_car;
                    end else begin
                        // dispatch inside the interrupt routine degrades to NEXT and flags an error
                        if (uop == UOP_DISPATCH) begin
                            r_seq_err <= 1'b1;
                        end
                        if (uop == UOP_JUMP && ucond) begin
                            r_car <= utarget;
                        end else begin
                            r_car <= w_car_inc;
                            if (w_car_max) begin
                                r_seq_err <= 1'b1;
                            end
                        end
                    end
                end
`ifdef CARSEQ_SINGLE_STEP_EN
                ST_HALT: begin
                    if (step) begin
                        r_state <= ST_FETCH;
                    end
                end
`endif
                default: begin
                    r_car   <= C_FETCH;
                    r_state <= ST_FETCH;
                end
            endcase
        end
    end

    assign iw_ready = (r_state == ST_FETCH) && !stall;
    assign ir       = r_ir;
    assign car      = r_car;
    assign in_irq   = r_in_irq;
    assign irq_ack  = r_irq_ack;
    assign seq_err  = r_seq_err;

endmodule

// File: tb/tb_car_sequencer.sv
// Self-checking bench for car_sequencer: a phase-level reference model compared every
// cycle, plus literal expectations along directed instruction sequences.
module tb_car_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] iw;
    logic        iw_valid;
    logic        iw_ready;
    logic [15:0] ir;
    logic [5:0]  dec_car;
    logic [1:0]  uop;
    logic [5:0]  utarget;
    logic        ucond;
    logic        stall;
    logic        irq;
    logic        gie;
    logic [5:0]  car;
    logic        in_irq;
    logic        irq_ack;
    logic        seq_err;

    int n_total = 0;
    int n_bad   = 0;
    bit chk_en  = 1'b0;

    car_sequencer dut (
        .clk     (clk),
        .reset   (reset),
        .iw      (iw),
        .iw_valid(iw_valid),
        .iw_ready(iw_ready),
        .ir      (ir),
        .dec_car (dec_car),
        .uop     (uop),
        .utarget (utarget),
        .ucond   (ucond),
        .stall   (stall),
        .irq     (irq),
        .gie     (gie),
        .car     (car),
        .in_irq  (in_irq),
        .irq_ack (irq_ack),
        .seq_err (seq_err)
    );

    always #5 clk = ~clk;

    // Reference model: where the sequencer is in the instruction lifecycle
    localparam int PH_IDLE    = 0;
    localparam int PH_DECODE  = 1;
    localparam int PH_ROUTINE = 2;
    localparam int PH_INTR    = 3;

    int          m_phase;
    int          m_car;
    logic [15:0] m_ir;
    bit          m_in_irq;
    bit          m_ack;
    bit          m_err;

    always @(posedge clk) begin
        if (reset) begin
            m_phase  = PH_IDLE;
            m_car    = 0;
            m_ir     = 16'h0000;
            m_in_irq = 0;
            m_ack    = 0;
            m_err    = 0;
        end else begin
            m_ack = 0;
            if (!stall) begin
                if (m_phase == PH_IDLE) begin
                    if (iw_valid) begin
                        m_ir    = iw;
                        m_phase = PH_DECODE;
                    end
                end else if (m_phase == PH_DECODE) begin
                    m_car   = int'(dec_car);
                    m_phase = PH_ROUTINE;
                end else if (uop == 2'd3) begin
                    if (m_phase == PH_ROUTINE && irq && gie) begin
                        m_car    = 62;
                        m_in_irq = 1;
                        m_ack    = 1;
                        m_phase  = PH_INTR;
                    end else begin
                        m_car    = 0;
                        m_in_irq = 0;
                        m_phase  = PH_IDLE;
                    end
                end else if (uop == 2'd2 && m_phase == PH_ROUTINE) begin
                    m_car = int'(dec_car);
                end else begin
                    if (uop == 2'd2) m_err = 1;
                    if (uop == 2'd1 && ucond) begin
                        m_car = int'(utarget);
                    end else begin
                        if (m_car == 63) m_err = 1;
                        m_car = (m_car + 1) % 64;
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model car", 16'(car), 16'(m_car[5:0]));
            chk("model ir", ir, m_ir);
            chk("model in_irq", 16'(in_irq), 16'(m_in_irq));
            chk("model irq_ack", 16'(irq_ack), 16'(m_ack));
            chk("model seq_err", 16'(seq_err), 16'(m_err));
            chk("model iw_ready", 16'(iw_ready), 16'(m_phase == PH_IDLE && !stall));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic run_to_exec(input logic [15:0] word, input logic [5:0] dc);
        iw       = word;
        iw_valid = 1'b1;
        dec_car  = dc;
        uop      = 2'd0;
        tick();
        iw_valid = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b1; iw = 16'h0; iw_valid = 1'b0; dec_car = 6'd0; uop = 2'd0;
        utarget = 6'd0; ucond = 1'b0; stall = 1'b0; irq = 1'b0; gie = 1'b0;
        tick();
        chk_en = 1'b1;
        tick();
        reset = 1'b0;

        // reset mid-routine
        run_to_exec(16'h1234, 6'd17);
        chk("exec car 17", 16'(car), 16'd17);
        reset = 1'b1;
        tick();
        chk("reset car after 1", 16'(car), 16'd0);
        tick();
        reset = 1'b0;
        chk("reset car", 16'(car), 16'd0);
        chk("reset ir", ir, 16'h0000);
        chk("reset iw_ready", 16'(iw_ready), 16'd1);
        chk("reset seq_err", 16'(seq_err), 16'd0);
        chk("reset in_irq", 16'(in_irq), 16'd0);

        // fetch / dispatch / NEXT, NEXT, END
        chk("fetch car 0", 16'(car), 16'd0);
        iw = 16'h4505; iw_valid = 1'b1; dec_car = 6'd12; uop = 2'd0;
        tick();
        iw_valid = 1'b0;
        chk("dispatch car 0", 16'(car), 16'd0);
        chk("fetch ir", ir, 16'h4505);
        chk("dispatch iw_ready", 16'(iw_ready), 16'd0);
        tick();
        chk("exec car 12", 16'(car), 16'd12);
        tick();
        chk("exec car 13", 16'(car), 16'd13);
        tick();
        chk("exec car 14", 16'(car), 16'd14);
        uop = 2'd3;
        tick();
        chk("end car 0", 16'(car), 16'd0);
        chk("end iw_ready", 16'(iw_ready), 16'd1);

        // conditional jump taken / not taken
        run_to_exec(16'h1000, 6'd20);
        uop = 2'd1; utarget = 6'd40; ucond = 1'b1;
        tick();
        chk("jump taken", 16'(car), 16'd40);
        uop = 2'd3;
        tick();
        run_to_exec(16'h1001, 6'd20);
        uop = 2'd1; ucond = 1'b0;
        tick();
        chk("jump not taken", 16'(car), 16'd21);
        uop = 2'd3;
        tick();

        // interrupt entry with gie=1
        run_to_exec(16'h2000, 6'd5);
        irq = 1'b1; gie = 1'b1; uop = 2'd3;
        tick();
        chk("irq car", 16'(car), 16'd62);
        chk("irq ack", 16'(irq_ack), 16'd1);
        chk("irq in_irq", 16'(in_irq), 16'd1);
        uop = 2'd0;
        tick();
        chk("irq ack pulse", 16'(irq_ack), 16'd0);
        chk("irq car 63", 16'(car), 16'd63);
        uop = 2'd3;
        tick();
        chk("irq end car", 16'(car), 16'd0);
        chk("irq end in_irq", 16'(in_irq), 16'd0);
        // gie=0: no entry although irq stays high
        gie = 1'b0;
        run_to_exec(16'h2001, 6'd8);
        uop = 2'd3;
        tick();
        chk("gie0 car", 16'(car), 16'd0);
        chk("gie0 ack", 16'(irq_ack), 16'd0);
        irq = 1'b0;

        // stall during EXEC
        run_to_exec(16'h0D0D, 6'd13);
        uop = 2'd0; stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall car hold", 16'(car), 16'd13);
            chk("stall iw_ready", 16'(iw_ready), 16'd0);
        end
        stall = 1'b0;
        tick();
        chk("stall resume", 16'(car), 16'd14);
        uop = 2'd3;
        tick();
        // stall in FETCH blocks the IR load
        stall = 1'b1; iw = 16'h9999; iw_valid = 1'b1;
        tick();
        chk("fetch stall ir", ir, 16'h0D0D);
        chk("fetch stall iw_ready", 16'(iw_ready), 16'd0);
        iw_valid = 1'b0; stall = 1'b0;
        tick();
        chk("fetch stall car", 16'(car), 16'd0);

        // wrap-around
        run_to_exec(16'h5000, 6'd30);
        uop = 2'd1; utarget = 6'd63; ucond = 1'b1;
        tick();
        chk("wrap car 63", 16'(car), 16'd63);
        chk("wrap err before", 16'(seq_err), 16'd0);
        uop = 2'd0;
        tick();
        chk("wrap car 0", 16'(car), 16'd0);
        chk("wrap err set", 16'(seq_err), 16'd1);
        uop = 2'd3;
        tick();
        run_to_exec(16'h5001, 6'd2);
        uop = 2'd3;
        tick();
        chk("wrap err sticky", 16'(seq_err), 16'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("wrap err cleared", 16'(seq_err), 16'd0);

        // dispatch inside the interrupt routine is illegal
        run_to_exec(16'h6000, 6'd7);
        irq = 1'b1; gie = 1'b1; uop = 2'd3;
        tick();
        irq = 1'b0; uop = 2'd2; dec_car = 6'd9;
        tick();
        chk("irq dispatch car", 16'(car), 16'd63);
        chk("irq dispatch err", 16'(seq_err), 16'd1);
        uop = 2'd3;
        tick();
        chk("irq dispatch end", 16'(car), 16'd0);

        // second-level dispatch in EXEC
        run_to_exec(16'h7000, 6'd10);
        uop = 2'd2; dec_car = 6'd33;
        tick();
        chk("exec dispatch car", 16'(car), 16'd33);
        uop = 2'd3;
        tick();
        chk("final car", 16'(car), 16'd0);

        tick();
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
